// File: rtl/tidc_l2_mem_model.sv
// L2 backing-store responder: full-line memory behind a bounded in-order command queue
// with fixed response latency, cmd backpressure, error reporting and a sticky drop flag.
module tidc_l2_mem_model #(
  parameter int         DATA_W            = 512,
  parameter int         ADDR_W            = 64,
  parameter int         LINE_B            = 64,
  parameter int         DEPTH             = 1024,
  parameter int         LATENCY           = 1,
  parameter int         QDEPTH            = 4,
  parameter logic [2:0] L2_CMD_READ       = 3'd0,
  parameter logic [2:0] L2_CMD_WRITE      = 3'd1,
  parameter logic [2:0] L2_CMD_WRITE_BACK = 3'd2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           l2_cmd_valid,
  input  logic [2:0]                     l2_cmd_type,
  input  logic [ADDR_W-1:0]              l2_cmd_addr,
  input  logic [DATA_W-1:0]              l2_cmd_data,
  input  logic [3:0]                     l2_cmd_size,
  input  logic                           l2_cmd_dirty,
  output logic                           l2_cmd_ready,
  output logic                           l2_response_valid,
  output logic [DATA_W-1:0]              l2_response_data,
  output logic                           l2_response_error,
  output logic [$clog2(QDEPTH+1)-1:0]    occupancy,
  output logic                           drop_sticky
);

  localparam int OFFS  = $clog2(LINE_B);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW    = $clog2(QDEPTH+1);
  localparam logic [ADDR_W-1:0] IN_RANGE = {ADDR_W{1'b1}} >> (ADDR_W - OFFS - IDX_W);
  // Timer counts edges still to wait after the accept edge; 0 means the head responds now,
  // so LATENCY=1 responds in the cycle right after the accept edge.
  localparam logic [TW-1:0] T_PUSH = TW'(LATENCY - 1);

  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic              q_err  [QDEPTH];
  logic [TW-1:0]     q_timer_q [QDEPTH];
  logic [TW-1:0]     q_timer_d [QDEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] held_q, held_d;

  logic [IDX_W-1:0]  idx;
  logic              is_read, is_write, cmd_err, accept, pop, mem_we;
  logic [DATA_W-1:0] push_data;
  logic              unused_inputs;

  assign unused_inputs = ^{l2_cmd_size, l2_cmd_dirty, l2_cmd_addr[OFFS-1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    idx       = l2_cmd_addr[OFFS+IDX_W-1:OFFS];
    is_read   = (l2_cmd_type == L2_CMD_READ);
    is_write  = (l2_cmd_type == L2_CMD_WRITE) || (l2_cmd_type == L2_CMD_WRITE_BACK);
    cmd_err   = (|(l2_cmd_addr & ~IN_RANGE)) || !(is_read || is_write);
    accept    = l2_cmd_valid && l2_cmd_ready;
    pop       = (count_q != '0) && (q_timer_q[rd_ptr_q] == '0);
    mem_we    = accept && is_write && !cmd_err;
    push_data = cmd_err ? '0 : (is_write ? l2_cmd_data : mem[idx]);
  end

  always_comb begin
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(accept) - CW'(pop);
    drop_d   = drop_q || (l2_cmd_valid && !l2_cmd_ready);
    held_d   = pop ? q_data[rd_ptr_q] : held_q;
    for (int i = 0; i < QDEPTH; i++) begin
      q_timer_d[i] = (q_timer_q[i] != '0) ? q_timer_q[i] - TW'(1) : '0;
      if (accept && (wr_ptr_q == PW'(i))) begin
        q_timer_d[i] = T_PUSH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
      held_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) q_timer_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      held_q   <= held_d;
      for (int i = 0; i < QDEPTH; i++) q_timer_q[i] <= q_timer_d[i];
    end
  end

  // Payload storage is not reset: count/pointers alone decide which entries are live,
  // and committed memory contents must survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= l2_cmd_data;
    if (accept) begin
      q_data[wr_ptr_q] <= push_data;
      q_err[wr_ptr_q]  <= cmd_err;
    end
  end

  assign l2_cmd_ready      = (count_q < CW'(QDEPTH));
  assign l2_response_valid = pop;
  assign l2_response_error = pop && q_err[rd_ptr_q];
  assign l2_response_data  = pop ? q_data[rd_ptr_q] : held_q;
  assign occupancy         = count_q;
  assign drop_sticky       = drop_q;

endmodule

// File: tb/tb_tidc_l2_mem_model.sv
// Directed bench for tidc_l2_mem_model: three instances (LATENCY 1/3/4) share one command
// stream; each step checks the instance the scenario targets.
module tb_tidc_l2_mem_model;

  localparam logic [2:0] RD = 3'd0, WR = 3'd1, WB = 3'd2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_type = RD;
  logic [63:0]  cmd_addr = '0;
  logic [511:0] cmd_data = '0;
  logic [3:0]   cmd_size = 4'hf;
  logic         cmd_dirty = 1'b0;

  logic a_rdy, a_vld, a_err, a_drop; logic [511:0] a_data; logic [2:0] a_occ;
  logic b_rdy, b_vld, b_err, b_drop; logic [511:0] b_data; logic [2:0] b_occ;
  logic c_rdy, c_vld, c_err, c_drop; logic [511:0] c_data; logic [1:0] c_occ;

  int errors = 0;
  int checks = 0;
  int c_pulses = 0;
  int c_base;

  logic [511:0] P = {16{32'hA5A5_0001}};
  logic [511:0] D = {16{32'hDEAD_BEEF}};
  logic [511:0] Z = {16{32'h0000_1234}};
  logic [511:0] X = {16{32'hBAD0_BAD0}};
  logic [511:0] Y = {16{32'h7777_7777}};

  always #5 clk = ~clk;

  tidc_l2_mem_model #(.LATENCY(1), .QDEPTH(4), .L2_CMD_READ(RD), .L2_CMD_WRITE(WR),
                      .L2_CMD_WRITE_BACK(WB)) dut_a (
    .clk(clk), .rst_n(rst_n), .l2_cmd_valid(cmd_valid), .l2_cmd_type(cmd_type),
    .l2_cmd_addr(cmd_addr), .l2_cmd_data(cmd_data), .l2_cmd_size(cmd_size),
    .l2_cmd_dirty(cmd_dirty), .l2_cmd_ready(a_rdy), .l2_response_valid(a_vld),
    .l2_response_data(a_data), .l2_response_error(a_err), .occupancy(a_occ),
    .drop_sticky(a_drop));

  tidc_l2_mem_model #(.LATENCY(3), .QDEPTH(4), .L2_CMD_READ(RD), .L2_CMD_WRITE(WR),
                      .L2_CMD_WRITE_BACK(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .l2_cmd_valid(cmd_valid), .l2_cmd_type(cmd_type),
    .l2_cmd_addr(cmd_addr), .l2_cmd_data(cmd_data), .l2_cmd_size(cmd_size),
    .l2_cmd_dirty(cmd_dirty), .l2_cmd_ready(b_rdy), .l2_response_valid(b_vld),
    .l2_response_data(b_data), .l2_response_error(b_err), .occupancy(b_occ),
    .drop_sticky(b_drop));

  tidc_l2_mem_model #(.LATENCY(4), .QDEPTH(2), .L2_CMD_READ(RD), .L2_CMD_WRITE(WR),
                      .L2_CMD_WRITE_BACK(WB)) dut_c (
    .clk(clk), .rst_n(rst_n), .l2_cmd_valid(cmd_valid), .l2_cmd_type(cmd_type),
    .l2_cmd_addr(cmd_addr), .l2_cmd_data(cmd_data), .l2_cmd_size(cmd_size),
    .l2_cmd_dirty(cmd_dirty), .l2_cmd_ready(c_rdy), .l2_response_valid(c_vld),
    .l2_response_data(c_data), .l2_response_error(c_err), .occupancy(c_occ),
    .drop_sticky(c_drop));

  always @(negedge clk) if (c_vld === 1'b1) c_pulses++;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] t, input logic [63:0] a, input logic [511:0] d);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    check("rst_vld", a_vld, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_data", a_data, '0);
    check("rst_occ", a_occ, 3'd0);
    check("rst_ready", a_rdy, 1'b1);
    check("rst_drop", a_drop, 1'b0);
    rst_n = 1'b1;

    // 1: preload line 0x40 via address 0x1000, then read it back at LATENCY=1
    cmd(WR, 64'h1000, P); step();
    check("t1_wr_vld", a_vld, 1'b1);
    check("t1_wr_echo", a_data, P);
    cmd(RD, 64'h1000, '0); step();
    check("t1_rd_vld", a_vld, 1'b1);
    check("t1_rd_data", a_data, P);
    check("t1_rd_err", a_err, 1'b0);
    check("t1_occ", a_occ, 3'd1);
    idle(); step();
    check("t1_vld_low", a_vld, 1'b0);
    check("t1_data_held", a_data, P);
    repeat (6) step();

    // 2: write then read on consecutive cycles at LATENCY=3
    cmd(WR, 64'h1000, D); step();
    check("t2_vld0", b_vld, 1'b0);
    check("t2_occ1", b_occ, 3'd1);
    cmd(RD, 64'h1000, '0); step();
    check("t2_vld1", b_vld, 1'b0);
    check("t2_occ2", b_occ, 3'd2);
    idle(); step();
    check("t2_wr_vld", b_vld, 1'b1);
    check("t2_wr_data", b_data, D);
    check("t2_wr_err", b_err, 1'b0);
    step();
    check("t2_rd_vld", b_vld, 1'b1);
    check("t2_rd_data", b_data, D);
    check("t2_rd_occ", b_occ, 3'd1);
    step();
    check("t2_done_vld", b_vld, 1'b0);
    check("t2_done_occ", b_occ, 3'd0);
    repeat (6) step();

    // 3 and 6: out-of-range address and unknown type on LATENCY=1
    cmd(WR, 64'h0, Z); step();
    check("t3_wr0_err", a_err, 1'b0);
    cmd(RD, 64'h1_0000_0000, '0); step();
    check("t3_rd_vld", a_vld, 1'b1);
    check("t3_rd_err", a_err, 1'b1);
    check("t3_rd_data", a_data, '0);
    cmd(WR, 64'h1_0000_0000, X); step();
    check("t3_wr_err", a_err, 1'b1);
    check("t3_wr_data", a_data, '0);
    cmd(RD, 64'h0, '0); step();
    check("t3_mem_kept", a_data, Z);
    check("t3_mem_err", a_err, 1'b0);
    cmd(3'b111, 64'h0, Y); step();
    check("t6_vld", a_vld, 1'b1);
    check("t6_err", a_err, 1'b1);
    check("t6_data", a_data, '0);
    idle(); step();
    check("t6_single", a_vld, 1'b0);
    check("t6_held", a_data, '0);
    cmd(RD, 64'h0, '0); step();
    check("t6_mem_kept", a_data, Z);
    idle();
    repeat (6) step();

    // 5: three reads in flight at LATENCY=3, reset mid-flight
    cmd(RD, 64'h1000, '0); step(); step(); step();
    idle();
    check("t5_occ3", b_occ, 3'd3);
    check("t5_c_drop_pre", c_drop, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_vld", b_vld, 1'b0);
    check("t5_rst_occ", b_occ, 3'd0);
    check("t5_rst_ready", b_rdy, 1'b1);
    check("t5_rst_cdrop", c_drop, 1'b0);
    check("t5_rst_cocc", c_occ, 2'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_b_pulse", b_vld, 1'b0);
      check("t5_no_c_pulse", c_vld, 1'b0);
    end
    cmd(RD, 64'h1000, '0); step();
    check("t5_reread_vld", a_vld, 1'b1);
    check("t5_reread_data", a_data, D);
    idle();
    repeat (6) step();

    // 4: LATENCY=4, QDEPTH=2, valid held for 6 cycles
    c_base = c_pulses;
    check("t4_drop_pre", c_drop, 1'b0);
    cmd(RD, 64'h1000, '0);
    step(); step();
    check("t4_full_ready", c_rdy, 1'b0);
    check("t4_full_occ", c_occ, 2'd2);
    step(); step();
    check("t4_rsp1_vld", c_vld, 1'b1);
    check("t4_rsp1_data", c_data, D);
    check("t4_drop", c_drop, 1'b1);
    step();
    check("t4_rsp2_vld", c_vld, 1'b1);
    check("t4_ready_back", c_rdy, 1'b1);
    check("t4_occ_pop", c_occ, 2'd1);
    step();
    idle();
    check("t4_gap_vld", c_vld, 1'b0);
    check("t4_occ_third", c_occ, 2'd1);
    step(); step();
    check("t4_gap2_vld", c_vld, 1'b0);
    step();
    check("t4_rsp3_vld", c_vld, 1'b1);
    step();
    check("t4_end_vld", c_vld, 1'b0);
    check("t4_end_occ", c_occ, 2'd0);
    check("t4_pulses", 512'(c_pulses - c_base), 512'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
